// File: rtl/alu_flags_pkg.sv
// -----------------------------------------------------------------------------
// alu_flags_pkg
// Shared definitions for the ALU condition-flag unit: flag bit indices, the
// flag word type, the write mask that keeps the parity bit at zero when
// parity support is compiled out, and the control request bundle.
//
// Configuration macro: FLAGS_PARITY_EN (enables flag bit 7 = even parity).
// -----------------------------------------------------------------------------
package alu_flags_pkg;

    localparam int FLAG_W = 8;

    typedef logic [FLAG_W-1:0] flag_word_t;

    localparam int FLG_Z  = 0;
    localparam int FLG_C  = 1;
    localparam int FLG_EQ = 2;
    localparam int FLG_LT = 3;
    localparam int FLG_GT = 4;
    localparam int FLG_N  = 5;
    localparam int FLG_V  = 6;
    localparam int FLG_P  = 7;

    // Applied to every value written into the flags register so the parity
    // bit can never become 1 when the feature is absent (ld and pop included).
`ifdef FLAGS_PARITY_EN
    localparam flag_word_t FLAG_WR_MASK = 8'hFF;
`else
    localparam flag_word_t FLAG_WR_MASK = 8'h7F;
`endif

    // Per-cycle register control request.
    typedef struct packed {
        logic push;
        logic pop;
        logic ld;
        logic upd;
        logic err_clr;
    } flag_req_t;

endpackage

// File: rtl/alu_flags_stack.sv
// -----------------------------------------------------------------------------
// alu_flags_stack
// STACK_DEPTH x 8-bit LIFO for saving/restoring the flag word.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset (clears occupancy only)
//   push, pop   - save wdata / drop top; both together is a no-op
//   wdata       - word to save on push
//   rdata       - current top of stack (zero when empty)
//   depth       - occupancy, never wraps
//   full, empty - occupancy == STACK_DEPTH / occupancy == 0
// -----------------------------------------------------------------------------
module alu_flags_stack
    import alu_flags_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  flag_word_t       wdata,
    output flag_word_t       rdata,
    output logic [PTR_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_MAX = PTR_W'(STACK_DEPTH);

    flag_word_t       mem [STACK_DEPTH];
    logic [PTR_W-1:0] depth_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    // Simultaneous push+pop cancels: the pushed word would just be popped.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;

    assign wr_idx = IDX_W'(depth_q);
    assign rd_idx = IDX_W'(depth_q - 1'b1);

    assign depth = depth_q;
    assign full  = (depth_q == DEPTH_MAX);
    assign empty = (depth_q == '0);
    assign rdata = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + 1'b1;
        end else if (do_pop) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    // Storage needs no reset: entries above depth are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/alu_flags_unit.sv
// -----------------------------------------------------------------------------
// alu_flags_unit
// Decodes eight condition flags from an ALU result and its active-low carry
// chain, and keeps them in a status register with masked update, software
// load, a save/restore stack and a sticky stack-error bit.
//
// Configuration macro: FLAGS_PARITY_EN (flag bit 7 = even parity of f;
// otherwise bit 7 is always 0).
//
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   f, a_b, cn_n,
//   cout_n, a_msb, b_msb - ALU result and side signals to decode
//   upd, upd_mask       - masked latch of decoded flags
//   ld, ld_data         - software load of the flags register
//   push, pop           - save / restore flags via the stack
//   err_clr             - clears the sticky err bit
//   flags               - registered status flags
//   flags_dec           - combinational decode of the current inputs
//   depth, full, empty  - stack occupancy status
//   err                 - sticky stack overflow/underflow
// -----------------------------------------------------------------------------
module alu_flags_unit
    import alu_flags_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] f,
    input  logic             a_b,
    input  logic             cn_n,
    input  logic             cout_n,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             upd,
    input  logic [7:0]       upd_mask,
    input  logic             ld,
    input  logic [7:0]       ld_data,
    input  logic             push,
    input  logic             pop,
    output logic [7:0]       flags,
    output logic [7:0]       flags_dec,
    output logic [PTR_W-1:0] depth,
    output logic             full,
    output logic             empty,
    output logic             err,
    input  logic             err_clr
);

    flag_req_t  req;
    flag_word_t dec;
    flag_word_t flags_q;
    flag_word_t flags_nxt;
    flag_word_t stk_top;
    logic       restore;
    logic       new_err;
    logic       err_q;

    assign req = '{push: push, pop: pop, ld: ld, upd: upd, err_clr: err_clr};

    // ---------------- flag decode ----------------
    always_comb begin
        dec         = '0;
        dec[FLG_Z]  = ~|f;
        dec[FLG_C]  = ~cout_n;
        dec[FLG_EQ] = a_b;
        dec[FLG_LT] = ~cn_n & cout_n;
        dec[FLG_GT] = cn_n & ~cout_n;
        dec[FLG_N]  = f[WIDTH-1];
        // Overflow: operands agree in sign but the result does not.
        dec[FLG_V]  = (a_msb == b_msb) & (f[WIDTH-1] != a_msb);
`ifdef FLAGS_PARITY_EN
        dec[FLG_P]  = ~^f;
`endif
    end

    assign flags_dec = dec;

    // ---------------- stack ----------------
    alu_flags_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PTR_W       (PTR_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req.push),
        .pop   (req.pop),
        .wdata (flags_q),
        .rdata (stk_top),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // A pop with data available restores even when paired with push; the
    // stack itself treats that pair as a no-op, so the top is reloaded.
    assign restore = req.pop & ~empty;

    always_comb begin
        flags_nxt = flags_q;
        if (restore) begin
            flags_nxt = stk_top;
        end else if (req.ld) begin
            flags_nxt = ld_data;
        end else if (req.upd) begin
            flags_nxt = (flags_q & ~upd_mask) | (dec & upd_mask);
        end
        flags_nxt = flags_nxt & FLAG_WR_MASK;
    end

    // Errors only on an unpaired push/pop against a full/empty stack.
    assign new_err = (req.push & ~req.pop & full) | (req.pop & ~req.push & empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_nxt;
            if (new_err) begin
                err_q <= 1'b1;
            end else if (req.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign flags = flags_q;
    assign err   = err_q;

endmodule

// File: tb/tb_alu_flags_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_flags_unit
// Directed-vector bench for alu_flags_unit (WIDTH=8, STACK_DEPTH=4). The
// driver queues hand-computed expected register state for each operation;
// a monitor compares it one edge later. Reset and decode outputs are
// checked directly.
// -----------------------------------------------------------------------------
module tb_alu_flags_unit;

    localparam int WIDTH = 8;
    localparam int SD    = 4;
    localparam int PW    = $clog2(SD + 1);

`ifdef FLAGS_PARITY_EN
    localparam logic [7:0] P  = 8'h80;
    localparam logic [7:0] PM = 8'hFF;
`else
    localparam logic [7:0] P  = 8'h00;
    localparam logic [7:0] PM = 8'h7F;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] f;
    logic             a_b, cn_n, cout_n, a_msb, b_msb;
    logic             upd, ld, push, pop, err_clr;
    logic [7:0]       upd_mask, ld_data;
    logic [7:0]       flags, flags_dec;
    logic [PW-1:0]    depth;
    logic             full, empty, err;

    alu_flags_unit #(.WIDTH(WIDTH), .STACK_DEPTH(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f         (f),
        .a_b       (a_b),
        .cn_n      (cn_n),
        .cout_n    (cout_n),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .upd       (upd),
        .upd_mask  (upd_mask),
        .ld        (ld),
        .ld_data   (ld_data),
        .push      (push),
        .pop       (pop),
        .flags     (flags),
        .flags_dec (flags_dec),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] fl;
        int         d;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare everything due on this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk({e.nm, ".flags"}, int'(flags), int'(e.fl));
                chk({e.nm, ".depth"}, int'(depth), e.d);
                chk({e.nm, ".full"},  int'(full),  int'(e.d == SD));
                chk({e.nm, ".empty"}, int'(empty), int'(e.d == 0));
                chk({e.nm, ".err"},   int'(err),   int'(e.e));
            end
        end
    end

    // One-edge operation with expected post-edge state.
    task automatic step(input logic i_push, input logic i_pop, input logic i_ld,
                        input logic [7:0] i_ldd, input logic i_upd, input logic [7:0] i_mask,
                        input logic i_clr, input string nm,
                        input logic [7:0] e_fl, input int e_d, input logic e_err);
        exp_t e;
        @(negedge clk);
        push = i_push; pop = i_pop; ld = i_ld; ld_data = i_ldd;
        upd = i_upd; upd_mask = i_mask; err_clr = i_clr;
        e.cyc = cyc + 1; e.nm = nm; e.fl = e_fl; e.d = e_d; e.e = e_err;
        q.push_back(e);
        @(posedge clk);
        #2;
        push = 0; pop = 0; ld = 0; upd = 0; err_clr = 0; upd_mask = 0; ld_data = 0;
    endtask

    initial begin
        rst_n = 0;
        f = 8'h01; a_b = 0; cn_n = 1; cout_n = 1; a_msb = 0; b_msb = 0;
        upd = 0; ld = 0; push = 0; pop = 0; err_clr = 0; upd_mask = 0; ld_data = 0;
        #3;
        chk("rst.flags", int'(flags), 0);
        chk("rst.depth", int'(depth), 0);
        chk("rst.err",   int'(err),   0);
        chk("rst.empty", int'(empty), 1);
        chk("rst.full",  int'(full),  0);
        @(negedge clk);
        rst_n = 1;

        //     push pop ld  ldd    upd mask  clr name           flags      d  err
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pop_empty0",  8'h00,     0, 1);
        step(0, 0, 1, 8'hFF, 0, 8'h00, 0, "ld_ff",       8'hFF & PM, 0, 1);
        step(1, 0, 0, 8'h00, 0, 8'h00, 0, "push_pre",    8'hFF & PM, 1, 1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst.flags", int'(flags), 0);
        chk("arst.depth", int'(depth), 0);
        chk("arst.err",   int'(err),   0);
        @(negedge clk);
        rst_n = 1;

        // Decode: Z, C, GT (+P).
        f = 8'h00; cout_n = 0; cn_n = 1; a_b = 0; a_msb = 0; b_msb = 0;
        #1 chk("dec_zero", int'(flags_dec), int'(8'h13 | P));
        step(0, 0, 0, 8'h00, 1, 8'hFF, 0, "upd_all",     8'h13 | P, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h00, 0, "ld_00",       8'h00,     0, 0);

        // Masked update: only N passes, V blocked.
        f = 8'h80; cout_n = 1; cn_n = 1;
        #1 chk("dec_neg", int'(flags_dec), int'(8'h60));
        step(0, 0, 0, 8'h00, 1, 8'h20, 0, "upd_mask_n",  8'h20,     0, 0);

        // EQ, LT, V, even parity.
        f = 8'h03; cn_n = 0; cout_n = 1; a_b = 1; a_msb = 1; b_msb = 1;
        #1 chk("dec_lt", int'(flags_dec), int'(8'h4C | P));
        step(0, 0, 0, 8'h00, 1, 8'h0C, 0, "upd_mask_lt", 8'h2C,     0, 0);

        // Fill the stack, overflow, then drain and underflow.
        step(0, 0, 1, 8'h11, 0, 8'h00, 0, "ld_11",       8'h11, 0, 0);
        step(1, 0, 1, 8'h22, 0, 8'h00, 0, "push1",       8'h22, 1, 0);
        step(1, 0, 1, 8'h33, 0, 8'h00, 0, "push2",       8'h33, 2, 0);
        step(1, 0, 1, 8'h44, 0, 8'h00, 0, "push3",       8'h44, 3, 0);
        step(1, 0, 1, 8'h55, 0, 8'h00, 0, "push4",       8'h55, 4, 0);
        step(1, 0, 0, 8'h00, 0, 8'h00, 0, "push_full",   8'h55, 4, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pop1",        8'h44, 3, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pop2",        8'h33, 2, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pop3",        8'h22, 1, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pop4",        8'h11, 0, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pop_empty",   8'h11, 0, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, "err_clr",     8'h11, 0, 0);

        // push + upd saves the old value.
        f = 8'h01; cn_n = 0; cout_n = 0; a_b = 0; a_msb = 0; b_msb = 0;
        step(0, 0, 1, 8'h01, 0, 8'h00, 0, "ld_01",       8'h01, 0, 0);
        step(1, 0, 0, 8'h00, 1, 8'h03, 0, "push_upd",    8'h02, 1, 0);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pop_old",     8'h01, 0, 0);

        // push + pop at depth 2.
        step(0, 0, 1, 8'h0A, 0, 8'h00, 0, "ld_0a",       8'h0A, 0, 0);
        step(1, 0, 1, 8'h0B, 0, 8'h00, 0, "pp_push1",    8'h0B, 1, 0);
        step(1, 0, 1, 8'h0C, 0, 8'h00, 0, "pp_push2",    8'h0C, 2, 0);
        step(1, 1, 0, 8'h00, 0, 8'h00, 0, "push_pop",    8'h0B, 2, 0);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pp_pop1",     8'h0B, 1, 0);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "pp_pop2",     8'h0A, 0, 0);

        // New error beats err_clr.
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, "err_set",     8'h0A, 0, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 1, "err_clr_vs",  8'h0A, 0, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, "err_clr2",    8'h0A, 0, 0);

        // pop beats ld; pop on empty lets ld through.
        step(1, 0, 0, 8'h00, 0, 8'h00, 0, "push_0a",     8'h0A, 1, 0);
        step(0, 1, 1, 8'h77, 0, 8'h00, 0, "pop_over_ld", 8'h0A, 0, 0);
        step(0, 1, 1, 8'h5A, 0, 8'h00, 0, "ld_on_uflow", 8'h5A, 0, 1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries never checked, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
